ram_port_arbiter_2x: RTL

- Shares one 1K x 8 single-port synchronous RAM (coincident_ram_1k8) between two independent requesters, A and B.
- Each requester uses a valid/ready request channel and a read-response channel.
- Grants go round-robin, with an optional bounded lock for back-to-back bursts.
- Sits directly in front of the RAM instance; it is the only driver of the RAM's we/addr/din.

---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/ram_port_arbiter_2x_if.sv | 61 ++++++
 rtl/ram_port_arbiter_2x_rr_pick2.sv | 46 ++++
 rtl/ram_port_arbiter_2x.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-requester RAM port arbiter:
//   - default RAM geometry (ADDR_W_DEF / DATA_W_DEF)
//   - requester id encoding used for last_grant, owner and read tag
//   - default and maximum burst lock length, and the burst counter width
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_MAX_DEF = 4;

  // Burst counter wide enough for the largest legal BURST_MAX (15).
  localparam int CNT_W = 4;

  // REQ_NONE is only meaningful for the lock owner; last_grant and the
  // read tag always hold REQ_A or REQ_B.
  typedef enum logic [1:0] {
    REQ_A    = 2'd0,
    REQ_B    = 2'd1,
    REQ_NONE = 2'd2
  } req_id_e;

endpackage

// File: rtl/ram_port_arbiter_2x_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_2x_if
// Bundles both requester channels and the RAM-facing bus of the arbiter.
//   Requester X (X = a, b):
//     x_valid/x_we/x_lock/x_addr/x_wdata : request, driven by the requester
//     x_ready                             : request accepted this cycle
//     x_rvalid/x_rdata                    : read response, one cycle later
//   RAM side:
//     ram_we/ram_addr/ram_din             : driven by the arbiter
//     ram_dout                            : registered RAM read data
// Modports:
//   slave  - the arbiter's view
//   master - the requesters' / RAM model's view
// ---------------------------------------------------------------------------
interface ram_port_arbiter_2x_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic              a_valid;
  logic              a_we;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ready;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_valid;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ready;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  a_valid, a_we, a_lock, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_lock, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output a_valid, a_we, a_lock, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_lock, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/ram_port_arbiter_2x_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker with bounded lock.
// Ports:
//   valid_i      [1:0]  request valids, bit0 = A, bit1 = B
//   last_grant_i        requester granted most recently (REQ_A/REQ_B)
//   owner_i             current lock owner, REQ_NONE when unlocked
//   burst_cnt_i         consecutive locked grants given to owner_i
//   gnt_o        [1:0]  one-hot grant (or zero), bit0 = A, bit1 = B
// A grant bit is only ever set for a requester whose valid is high.
// ---------------------------------------------------------------------------
module rr_pick2
  import ram_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic [1:0]       valid_i,
  input  req_id_e          last_grant_i,
  input  req_id_e          owner_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output logic [1:0]       gnt_o
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  always_comb begin
    gnt_o = 2'b00;
    unique case (valid_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        if (owner_i == REQ_NONE) begin
          // Plain round-robin: favour whoever was not served last.
          gnt_o = (last_grant_i == REQ_A) ? 2'b10 : 2'b01;
        end else if (burst_cnt_i < BURST_LIM) begin
          gnt_o = (owner_i == REQ_A) ? 2'b01 : 2'b10;
        end else begin
          // Burst budget spent while the other side waits: hand over.
          gnt_o = (owner_i == REQ_A) ? 2'b10 : 2'b01;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter_2x.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_2x
// Shares one single-port synchronous RAM between requesters A and B.
// Grants are round-robin with an optional bounded lock; the granted request
// drives the RAM in the same cycle, and read data returns on the requester's
// rvalid/rdata exactly one cycle after the grant.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - requester channels and RAM bus (ram_port_arbiter_2x_if.slave)
// Parameters:
//   ADDR_W, DATA_W - RAM geometry
//   BURST_MAX      - max consecutive locked grants while the other waits
// ---------------------------------------------------------------------------
module ram_port_arbiter_2x
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_2x_if.slave  bus
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  // Burst count increment that sticks at the lock limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= BURST_LIM) return BURST_LIM;
    return v + CNT_W'(1);
  endfunction

  req_id_e          last_grant_q, last_grant_d;
  req_id_e          owner_q,      owner_d;
  req_id_e          rd_tag_q,     rd_tag_d;
  logic [CNT_W-1:0] burst_cnt_q,  burst_cnt_d;
  logic             rd_pend_q,    rd_pend_d;

  logic [1:0]        valid_v;
  logic [1:0]        gnt;
  logic              any_gnt;
  req_id_e           g_id;
  logic              g_we;
  logic              g_lock;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              owner_keep;

  assign valid_v = {bus.b_valid, bus.a_valid};

  rr_pick2 #(
    .BURST_MAX (BURST_MAX)
  ) u_pick (
    .valid_i      (valid_v),
    .last_grant_i (last_grant_q),
    .owner_i      (owner_q),
    .burst_cnt_i  (burst_cnt_q),
    .gnt_o        (gnt)
  );

  assign any_gnt = |gnt;

  // Mux the granted request; everything is zero when nobody is granted,
  // which gives the idle RAM bus values directly.
  always_comb begin
    g_id    = REQ_A;
    g_we    = 1'b0;
    g_lock  = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    if (gnt[1]) begin
      g_id    = REQ_B;
      g_we    = bus.b_we;
      g_lock  = bus.b_lock;
      g_addr  = bus.b_addr;
      g_wdata = bus.b_wdata;
    end else if (gnt[0]) begin
      g_id    = REQ_A;
      g_we    = bus.a_we;
      g_lock  = bus.a_lock;
      g_addr  = bus.a_addr;
      g_wdata = bus.a_wdata;
    end
  end

  assign bus.a_ready  = gnt[0];
  assign bus.b_ready  = gnt[1];
  assign bus.ram_we   = g_we;
  assign bus.ram_addr = g_addr;
  assign bus.ram_din  = g_wdata;

  // Owner still holding its lock request (used only when it got no grant).
  always_comb begin
    owner_keep = 1'b0;
    unique case (owner_q)
      REQ_A:   owner_keep = bus.a_valid & bus.a_lock;
      REQ_B:   owner_keep = bus.b_valid & bus.b_lock;
      default: owner_keep = 1'b0;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    rd_pend_d    = 1'b0;
    rd_tag_d     = rd_tag_q;

    if (any_gnt) begin
      last_grant_d = g_id;
      if (g_lock) begin
        owner_d     = g_id;
        burst_cnt_d = (owner_q == g_id) ? sat_inc(burst_cnt_q) : CNT_W'(1);
      end else begin
        owner_d     = REQ_NONE;
        burst_cnt_d = '0;
      end
      if (!g_we) begin
        rd_pend_d = 1'b1;
        rd_tag_d  = g_id;
      end
    end else if (owner_q != REQ_NONE && !owner_keep) begin
      owner_d     = REQ_NONE;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_B;
      owner_q      <= REQ_NONE;
      burst_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= REQ_A;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  // RAM output is already registered, so the response is steered, not stored.
  assign bus.a_rvalid = rd_pend_q && (rd_tag_q == REQ_A);
  assign bus.b_rvalid = rd_pend_q && (rd_tag_q == REQ_B);
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;

endmodule
